elevator_floor_ctrl: RTL

- Car-position and scheduling controller for the elevator.
- Latches floor-call buttons and steps the car one floor at a time using a move timer.
- Holds the door open for a fixed time and chooses direction using collective (sweep) scheduling.
- Directly feeds the display stage: `floor` drives the 3-bit level inputs and `status` drives the 2-bit status inputs of the 7-segment multiplexer.

---
 rtl/elevator_floor_ctrl_if.sv | 22 ++
 rtl/elevator_floor_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/elevator_floor_ctrl_if.sv
// rtl/elevator_floor_ctrl_if.sv - call buttons in, car position and status out
interface elevator_floor_ctrl_if #(
  parameter int N_FLOORS = 5
);
  logic [N_FLOORS-1:0] call;
  logic [2:0]          floor;
  logic [1:0]          status;
  logic                door_open;
  logic [N_FLOORS-1:0] req_pending;

  // button panel / display side
  modport master (
    output call,
    input  floor, status, door_open, req_pending
  );

  // controller side
  modport slave (
    input  call,
    output floor, status, door_open, req_pending
  );
endinterface

// File: rtl/elevator_floor_ctrl.sv
// rtl/elevator_floor_ctrl.sv - elevator car position and sweep scheduling controller
module elevator_floor_ctrl #(
  parameter int N_FLOORS   = 5,
  parameter int MOVE_TICKS = 4,
  parameter int DOOR_TICKS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  elevator_floor_ctrl_if.slave bus
);

  localparam int MAX_TICKS = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
  localparam int TW        = $clog2(MAX_TICKS + 1);

  // encoding doubles as the status output
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    MOVE_UP   = 2'b01,
    MOVE_DOWN = 2'b10,
    DOOR      = 2'b11
  } state_t;

  state_t              state, state_nxt;
  logic [2:0]          cur_floor, floor_nxt;
  logic [TW-1:0]       timer, timer_nxt;
  logic [N_FLOORS-1:0] req, req_nxt;
  logic                last_down, last_down_nxt;

  logic ahead_up, ahead_dn, req_here, req_up1, req_dn1;
  logic go_up, go_dn;

  // decode the registered request set relative to the current floor
  always_comb begin
    ahead_up = 1'b0;
    ahead_dn = 1'b0;
    req_here = 1'b0;
    req_up1  = 1'b0;
    req_dn1  = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (3'(i) > cur_floor)             ahead_up = ahead_up | req[i];
      if (3'(i) < cur_floor)             ahead_dn = ahead_dn | req[i];
      if (3'(i) == cur_floor)            req_here = req[i];
      if (3'(i) == cur_floor + 3'd1)     req_up1  = req[i];
      if (3'(i) == cur_floor - 3'd1)     req_dn1  = req[i];
    end
    // keep sweeping in the last direction; only turn around when nothing lies ahead
    go_up = last_down ? (ahead_up && !ahead_dn) : ahead_up;
    go_dn = last_down ? ahead_dn : (ahead_dn && !ahead_up);
  end

  // next-state, floor stepping, timer and request latching
  always_comb begin
    state_nxt     = state;
    floor_nxt     = cur_floor;
    timer_nxt     = timer + TW'(1);
    last_down_nxt = last_down;
    req_nxt       = req | bus.call;

    case (state)
      IDLE: begin
        timer_nxt = '0;
        if (req_here) begin
          state_nxt = DOOR;
        end else if (go_up) begin
          state_nxt     = MOVE_UP;
          last_down_nxt = 1'b0;
        end else if (go_dn) begin
          state_nxt     = MOVE_DOWN;
          last_down_nxt = 1'b1;
        end
      end
      MOVE_UP: begin
        if (timer == TW'(MOVE_TICKS - 1)) begin
          floor_nxt = cur_floor + 3'd1;
          timer_nxt = '0;
          if (req_up1) state_nxt = DOOR;
        end
      end
      MOVE_DOWN: begin
        if (timer == TW'(MOVE_TICKS - 1)) begin
          floor_nxt = cur_floor - 3'd1;
          timer_nxt = '0;
          if (req_dn1) state_nxt = DOOR;
        end
      end
      DOOR: begin
        // req at this floor is always clear here, so only ahead() matters
        if (timer == TW'(DOOR_TICKS - 1)) begin
          if (go_up) begin
            state_nxt     = MOVE_UP;
            last_down_nxt = 1'b0;
          end else if (go_dn) begin
            state_nxt     = MOVE_DOWN;
            last_down_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt != state) timer_nxt = '0;

    // serving a floor absorbs its request, including calls pressed while the door is open
    if (state_nxt == DOOR || state == DOOR) begin
      for (int i = 0; i < N_FLOORS; i++) begin
        if (3'(i) == floor_nxt) req_nxt[i] = 1'b0;
      end
    end
  end

  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur_floor <= '0;
      timer     <= '0;
      req       <= '0;
      last_down <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_floor <= floor_nxt;
      timer     <= timer_nxt;
      req       <= req_nxt;
      last_down <= last_down_nxt;
    end
  end

  assign bus.floor       = cur_floor;
  assign bus.status      = state;
  assign bus.door_open   = (state == DOOR);
  assign bus.req_pending = req;

endmodule
